// File: rtl/spu_pkg.sv
// Shared types and sizing for the SPU result/write-back pipe.
// Slot entries hold {valid, rt, data}; lat_t carries execution-unit latency.
package spu_pkg;
  localparam int DATA_W  = 128;
  localparam int ADDR_W  = 7;
  localparam int MAX_LAT = 7;

  typedef logic [2:0] lat_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] rt;
    logic [DATA_W-1:0] data;
  } slot_t;

  function automatic logic lat_legal(input lat_t l);
    return (l != '0) && (int'(l) <= MAX_LAT);
  endfunction
endpackage

// File: rtl/spu_result_pipe_if.sv
// Issue handshake from the ID/EX boundary into the result pipe.
// ready is combinational from pipe state and the offered rt/lat.
interface spu_result_pipe_if;
  import spu_pkg::*;

  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] rt;
  lat_t              lat;
  logic [DATA_W-1:0] data;

  modport master (output valid, rt, lat, data, input ready);
  modport slave  (input valid, rt, lat, data, output ready);
endinterface

// File: rtl/spu_src_match.sv
// Compares one decode source address against every slot: combinational busy,
// plus matched slot data when SPU_FWD_EN is defined (zero when not busy).
module spu_src_match
  import spu_pkg::*;
(
  input  logic [MAX_LAT-1:0]             vld,
  input  logic [MAX_LAT-1:0][ADDR_W-1:0] rts,
`ifdef SPU_FWD_EN
  input  logic [MAX_LAT-1:0][DATA_W-1:0] datas,
  output logic [DATA_W-1:0]              fwd_data,
`endif
  input  logic [ADDR_W-1:0]              src,
  output logic                           busy
);
  always_comb begin
    busy = 1'b0;
`ifdef SPU_FWD_EN
    fwd_data = '0;
`endif
    // WAW stalling keeps matches unique, so OR-merging the data is exact
    for (int i = 0; i < MAX_LAT; i++) begin
      if (vld[i] && rts[i] == src) begin
        busy = 1'b1;
`ifdef SPU_FWD_EN
        fwd_data = fwd_data | datas[i];
`endif
      end
    end
  end
endmodule

// File: rtl/spu_result_pipe.sv
// Write-back delay line: result issued with latency L is written L cycles later; issue stalls
// on slot collision, WAW, flush or illegal latency. SPU_FWD_EN adds fwd_data_a/b/c bypass outputs.
module spu_result_pipe
  import spu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  spu_result_pipe_if.slave  issue,
  input  logic              flush,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  input  logic [ADDR_W-1:0] rc,
  output logic              busy_a,
  output logic              busy_b,
  output logic              busy_c,
`ifdef SPU_FWD_EN
  output logic [DATA_W-1:0] fwd_data_a,
  output logic [DATA_W-1:0] fwd_data_b,
  output logic [DATA_W-1:0] fwd_data_c,
`endif
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic              lat_err
);
  slot_t [MAX_LAT-1:0]             slots;
  slot_t [MAX_LAT-1:0]             slots_nxt;
  logic  [MAX_LAT-1:0]             vld;
  logic  [MAX_LAT-1:0][ADDR_W-1:0] rts;
  logic                            lat_ok;
  logic                            waw;
  logic                            slot_free;
  logic                            accept;

  always_comb begin
    lat_ok    = lat_legal(issue.lat);
    waw       = 1'b0;
    slot_free = 1'b1;
    // Slot L shifts into L-1 at this edge, so that is the one that must be empty
    for (int i = 0; i < MAX_LAT; i++) begin
      if (slots[i].valid && slots[i].rt == issue.rt) waw = 1'b1;
      if (i > 0 && int'(issue.lat) == i && slots[i].valid) slot_free = 1'b0;
    end
    issue.ready = lat_ok && slot_free && !waw && !flush;
  end

  assign accept = issue.valid && issue.ready;

  always_comb begin
    slots_nxt = '0;
    if (!flush) begin
      for (int i = 0; i < MAX_LAT - 1; i++) slots_nxt[i] = slots[i+1];
    end
    if (accept) begin
      for (int i = 0; i < MAX_LAT; i++) begin
        if (int'(issue.lat) == i + 1) slots_nxt[i] = '{1'b1, issue.rt, issue.data};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slots   <= '0;
      lat_err <= 1'b0;
    end else begin
      slots   <= slots_nxt;
      lat_err <= issue.valid && !lat_ok;
    end
  end

  assign rf_we = slots[0].valid;
  assign rf_wa = slots[0].rt;
  assign rf_wd = slots[0].data;

`ifdef SPU_FWD_EN
  logic [MAX_LAT-1:0][DATA_W-1:0] datas;
`endif

  always_comb begin
    for (int i = 0; i < MAX_LAT; i++) begin
      vld[i] = slots[i].valid;
      rts[i] = slots[i].rt;
`ifdef SPU_FWD_EN
      datas[i] = slots[i].data;
`endif
    end
  end

  spu_src_match u_match_a (
    .vld(vld), .rts(rts),
`ifdef SPU_FWD_EN
    .datas(datas), .fwd_data(fwd_data_a),
`endif
    .src(ra), .busy(busy_a)
  );

  spu_src_match u_match_b (
    .vld(vld), .rts(rts),
`ifdef SPU_FWD_EN
    .datas(datas), .fwd_data(fwd_data_b),
`endif
    .src(rb), .busy(busy_b)
  );

  spu_src_match u_match_c (
    .vld(vld), .rts(rts),
`ifdef SPU_FWD_EN
    .datas(datas), .fwd_data(fwd_data_c),
`endif
    .src(rc), .busy(busy_c)
  );
endmodule

// File: tb/tb_spu_result_pipe.sv
// Directed bench for spu_result_pipe: hand-computed write timing, stalls, flush and reset.
module tb_spu_result_pipe;
  import spu_pkg::*;

  logic              clk   = 1'b0;
  logic              reset = 1'b0;
  logic              flush = 1'b0;
  logic [ADDR_W-1:0] ra = '0, rb = '0, rc = '0;
  logic              busy_a, busy_b, busy_c;
  logic              rf_we, lat_err;
  logic [ADDR_W-1:0] rf_wa;
  logic [DATA_W-1:0] rf_wd;
`ifdef SPU_FWD_EN
  logic [DATA_W-1:0] fwd_data_a, fwd_data_b, fwd_data_c;
`endif

  int tests  = 0;
  int errors = 0;
  int w;

  localparam logic [DATA_W-1:0] DA5 = {16{8'hA5}};
  localparam logic [DATA_W-1:0] DD1 = {4{32'hD1D1_0001}};
  localparam logic [DATA_W-1:0] DD2 = {4{32'hD2D2_0002}};
  localparam logic [DATA_W-1:0] DF0 = {4{32'hF0F0_0000}};
  localparam logic [DATA_W-1:0] DF1 = {4{32'hF1F1_1111}};

  spu_result_pipe_if issue_if ();

  spu_result_pipe dut (
    .clk(clk), .reset(reset), .issue(issue_if), .flush(flush),
    .ra(ra), .rb(rb), .rc(rc),
    .busy_a(busy_a), .busy_b(busy_b), .busy_c(busy_c),
`ifdef SPU_FWD_EN
    .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b), .fwd_data_c(fwd_data_c),
`endif
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .lat_err(lat_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [ADDR_W-1:0] rt, input lat_t lat, input logic [DATA_W-1:0] d);
    issue_if.valid = 1'b1;
    issue_if.rt    = rt;
    issue_if.lat   = lat;
    issue_if.data  = d;
    #1;
  endtask

  task automatic idle();
    issue_if.valid = 1'b0;
    issue_if.rt    = '0;
    issue_if.lat   = 3'd1;
    issue_if.data  = '0;
  endtask

  task automatic count_writes(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      if (rf_we) cnt++;
      tick();
    end
  endtask

  initial begin
    idle();
    #2;
    chk("rst_we", DATA_W'(rf_we), '0);
    chk("rst_wa", DATA_W'(rf_wa), '0);
    chk("rst_wd", rf_wd, '0);
    chk("rst_laterr", DATA_W'(lat_err), '0);
    chk("rst_busy", DATA_W'(busy_a), '0);
    tick();
    tick();
    reset = 1'b1;

    // Reset mid-flight with slots 2 and 4 occupied
    offer(7'd20, 3'd5, DATA_W'(1));
    tick();
    idle();
    tick();
    offer(7'd21, 3'd5, DATA_W'(2));
    tick();
    idle();
    ra = 7'd20;
    rb = 7'd21;
    #1;
    chk("A_busy_slot2", DATA_W'(busy_a), DATA_W'(1));
    chk("A_busy_slot4", DATA_W'(busy_b), DATA_W'(1));
    reset = 1'b0;
    #1;
    chk("A_rst_we", DATA_W'(rf_we), '0);
    chk("A_rst_busy_a", DATA_W'(busy_a), '0);
    chk("A_rst_busy_b", DATA_W'(busy_b), '0);
    tick();
    tick();
    reset = 1'b1;
    count_writes(8, w);
    chk("A_no_writes", DATA_W'(w), '0);

    // Basic latency-3 write, busy visible cycles 1..3
    ra = 7'd5;
    rc = 7'd5;
    offer(7'd5, 3'd3, DA5);
    chk("B_ready", DATA_W'(issue_if.ready), DATA_W'(1));
    tick();
    idle();
    for (int c = 1; c <= 5; c++) begin
      chk("B_we", DATA_W'(rf_we), DATA_W'(c == 3));
      chk("B_busy_a", DATA_W'(busy_a), DATA_W'(c <= 3));
      if (c == 2) begin
        chk("B_busy_c", DATA_W'(busy_c), DATA_W'(1));
`ifdef SPU_FWD_EN
        chk("B_fwd_a", fwd_data_a, DA5);
`endif
      end
      if (c == 3) begin
        chk("B_wa", DATA_W'(rf_wa), DATA_W'(5));
        chk("B_wd", rf_wd, DA5);
      end
      tick();
    end

    // Slot collision: L=2 then L=1 next cycle
    offer(7'd10, 3'd2, DATA_W'(32'hC0));
    chk("C_ready0", DATA_W'(issue_if.ready), DATA_W'(1));
    tick();
    offer(7'd11, 3'd1, DATA_W'(32'hC1));
    chk("C_stall", DATA_W'(issue_if.ready), '0);
    tick();
    chk("C_we_first", DATA_W'(rf_we), DATA_W'(1));
    chk("C_wa_first", DATA_W'(rf_wa), DATA_W'(10));
    chk("C_ready2", DATA_W'(issue_if.ready), DATA_W'(1));
    tick();
    idle();
    chk("C_we_second", DATA_W'(rf_we), DATA_W'(1));
    chk("C_wa_second", DATA_W'(rf_wa), DATA_W'(11));
    chk("C_wd_second", rf_wd, DATA_W'(32'hC1));
    tick();
    chk("C_we_done", DATA_W'(rf_we), '0);

    // WAW hold: rt=9 L=5 then rt=9 L=1
    offer(7'd9, 3'd5, DD1);
    chk("D_ready0", DATA_W'(issue_if.ready), DATA_W'(1));
    tick();
    offer(7'd9, 3'd1, DD2);
    for (int c = 1; c <= 5; c++) begin
      chk("D_waw_stall", DATA_W'(issue_if.ready), '0);
      chk("D_we", DATA_W'(rf_we), DATA_W'(c == 5));
      if (c == 5) chk("D_wd_first", rf_wd, DD1);
      tick();
    end
    chk("D_ready6", DATA_W'(issue_if.ready), DATA_W'(1));
    chk("D_we6", DATA_W'(rf_we), '0);
    tick();
    idle();
    chk("D_we_second", DATA_W'(rf_we), DATA_W'(1));
    chk("D_wa_second", DATA_W'(rf_wa), DATA_W'(9));
    chk("D_wd_second", rf_wd, DD2);
    tick();
    chk("D_we_done", DATA_W'(rf_we), '0);

    // Illegal latency 0
    offer(7'd12, 3'd0, DATA_W'(32'hE));
    chk("E_ready", DATA_W'(issue_if.ready), '0);
    chk("E_laterr_pre", DATA_W'(lat_err), '0);
    tick();
    idle();
    chk("E_laterr", DATA_W'(lat_err), DATA_W'(1));
    chk("E_we", DATA_W'(rf_we), '0);
    tick();
    chk("E_laterr_end", DATA_W'(lat_err), '0);
    count_writes(4, w);
    chk("E_no_writes", DATA_W'(w), '0);

    // Flush with entries in slots 0 and 3
    rb = 7'd31;
    offer(7'd30, 3'd4, DF0);
    tick();
    idle();
    tick();
    tick();
    offer(7'd31, 3'd4, DF1);
    chk("F_ready_b", DATA_W'(issue_if.ready), DATA_W'(1));
    tick();
    idle();
    #1;
    chk("F_busy_b", DATA_W'(busy_b), DATA_W'(1));
`ifdef SPU_FWD_EN
    chk("F_fwd_b", fwd_data_b, DF1);
`endif
    flush = 1'b1;
    offer(7'd40, 3'd2, DATA_W'(32'h40));
    chk("F_flush_reject", DATA_W'(issue_if.ready), '0);
    chk("F_we0", DATA_W'(rf_we), DATA_W'(1));
    chk("F_wa0", DATA_W'(rf_wa), DATA_W'(30));
    chk("F_wd0", rf_wd, DF0);
    tick();
    flush = 1'b0;
    idle();
    #1;
    chk("F_busy_b_after", DATA_W'(busy_b), '0);
`ifdef SPU_FWD_EN
    chk("F_fwd_b_after", fwd_data_b, '0);
`endif
    count_writes(8, w);
    chk("F_no_writes", DATA_W'(w), '0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
